// File: rtl/shift_pkg.sv
// shift_pkg: shared state encoding, fill-mode constants and STEP legality check
package shift_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic SH_LOGICAL = 1'b0;
  localparam logic SH_ARITH = 1'b1;
  function automatic bit step_legal(input int step, input int width);
    return (step == 1 || step == 2 || step == 4 || step == 8) && step <= width;
  endfunction
endpackage

// File: rtl/shift_right_step.sv
// shift_right_step: one iteration, shifts acc right by k and back-fills the top k bits with fill
module shift_right_step #(
  parameter int WIDTH = 32,
  parameter int KW = 1
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [KW-1:0]    k,
  input  logic             fill,
  output logic [WIDTH-1:0] shifted
);
  logic [WIDTH-1:0] top_mask;
  // top_mask covers exactly the k vacated bits
  always_comb begin
    top_mask = ~({WIDTH{1'b1}} >> k);
    shifted = (acc >> k) | ({WIDTH{fill}} & top_mask);
  end
endmodule

// File: rtl/shift_right_iter.sv
// shift_right_iter: multi-cycle logical/arithmetic right shifter, up to STEP bits per clock
module shift_right_iter
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP = 1,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   shamt_i,
  input  logic             arith_i,
  output logic [WIDTH-1:0] data_o,
  output logic             done_o,
  output logic             ready_o
);
  localparam int KW = $clog2(STEP + 1);
  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic [SHW-1:0]   cnt;
  logic             fill;
  logic [KW-1:0]    k;
  if (!step_legal(STEP, WIDTH)) begin : g_bad_step
    $error("shift_right_iter: STEP must be 1, 2, 4 or 8 and not exceed WIDTH");
  end
  // k = min(STEP, cnt) so the last iteration never over-shifts
  always_comb begin
    k = (int'(cnt) < STEP) ? KW'(cnt) : KW'(STEP);
    ready_o = (state == IDLE);
  end
  shift_right_step #(.WIDTH(WIDTH), .KW(KW)) u_step (
    .acc(acc),
    .k(k),
    .fill(fill),
    .shifted(acc_nx)
  );
  // FSM: latch on accept, iterate until cnt drains, publish result with a one-cycle done
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      fill <= 1'b0;
      data_o <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          acc <= data_i;
          cnt <= shamt_i;
          fill <= (arith_i == SH_ARITH) & data_i[WIDTH-1];
          state <= SHIFT;
        end
        SHIFT: if (cnt == '0) begin
          data_o <= acc;
          done_o <= 1'b1;
          state <= DONE;
        end else begin
          acc <= acc_nx;
          cnt <= cnt - SHW'(k);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_right_iter.sv
// tb_shift_right_iter: directed scoreboard bench for STEP=1 and STEP=4 instances
module tb_shift_right_iter;
  import shift_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0;
  logic        start4 = 1'b0;
  logic [31:0] data = '0;
  logic [4:0]  shamt = '0;
  logic        arith = 1'b0;
  logic [31:0] q1, q4;
  logic        done1, done4, rdy1, rdy4;
  logic        sel = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] sb[$];
  logic [31:0] prev1 = '0;
  logic [31:0] prev4 = '0;
  always #5 clk = ~clk;
  shift_right_iter #(.WIDTH(32), .STEP(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .data_i(data), .shamt_i(shamt),
    .arith_i(arith), .data_o(q1), .done_o(done1), .ready_o(rdy1)
  );
  shift_right_iter #(.WIDTH(32), .STEP(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start4), .data_i(data), .shamt_i(shamt),
    .arith_i(arith), .data_o(q4), .done_o(done4), .ready_o(rdy4)
  );
  wire [31:0] q = sel ? q4 : q1;
  wire        done = sel ? done4 : done1;
  wire        rdy = sel ? rdy4 : rdy1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] ref_sh(input logic [31:0] d, input logic [4:0] s, input logic a);
    logic [31:0] r = d;
    for (int i = 0; i < int'(s); i++) r = {a & d[31], r[31:1]};
    return r;
  endfunction
  // accept one request on the selected instance, optionally poke start mid-shift, check latency/result/hold
  task automatic run(input string tag, input logic [31:0] d, input logic [4:0] s, input logic a,
                     input logic [31:0] exp, input bit inject);
    int step = sel ? 4 : 1;
    int exp_lat = (int'(s) + step - 1) / step + 1;
    int lat = 0;
    logic [31:0] held = sel ? prev4 : prev1;
    logic [31:0] got;
    sb.push_back(exp);
    @(negedge clk);
    chk({tag, "/ready_before"}, 32'(rdy), 32'd1);
    data = d; shamt = s; arith = a;
    if (sel) start4 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
    data = $urandom; shamt = 5'($urandom); arith = 1'($urandom);
    while (!done && lat < 64) begin
      chk({tag, "/ready_busy"}, 32'(rdy), 32'd0);
      chk({tag, "/hold_busy"}, q, held);
      if (inject && lat == 2) begin
        data = 32'hFFFF_FFFF; shamt = 5'd1; arith = SH_ARITH;
        if (sel) start4 = 1'b1; else start1 = 1'b1;
      end else begin
        start1 = 1'b0; start4 = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start1 = 1'b0; start4 = 1'b0;
    got = sb.pop_front();
    chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/result"}, q, got);
    chk({tag, "/ready_done"}, 32'(rdy), 32'd0);
    @(negedge clk);
    chk({tag, "/done_one_cycle"}, 32'(done), 32'd0);
    chk({tag, "/ready_after"}, 32'(rdy), 32'd1);
    chk({tag, "/hold_after"}, q, got);
    if (sel) prev4 = got; else prev1 = got;
  endtask
  initial begin
    int pulses;
    logic [31:0] rd;
    logic [4:0] rs;
    logic ra;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset/data1", q1, 32'h0);
      chk("reset/done1", 32'(done1), 32'd0);
      chk("reset/ready1", 32'(rdy1), 32'd1);
      chk("reset/data4", q4, 32'h0);
      chk("reset/ready4", 32'(rdy4), 32'd1);
    end
    sel = 1'b0;
    run("log4", 32'hF000_0001, 5'd4, SH_LOGICAL, 32'h0F00_0000, 0);
    run("ari31", 32'h8000_0000, 5'd31, SH_ARITH, 32'hFFFF_FFFF, 0);
    run("log31", 32'h8000_0000, 5'd31, SH_LOGICAL, 32'h0000_0001, 0);
    run("sh0", 32'hDEAD_BEEF, 5'd0, SH_ARITH, 32'hDEAD_BEEF, 0);
    run("ari_pos", 32'h7000_0000, 5'd3, SH_ARITH, 32'h0E00_0000, 0);
    run("inject", 32'hF000_0001, 5'd4, SH_LOGICAL, 32'h0F00_0000, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_hold/data", q1, 32'h0F00_0000);
      chk("idle_hold/ready", 32'(rdy1), 32'd1);
    end
    sel = 1'b1;
    run("s4_ari7", 32'h8765_4321, 5'd7, SH_ARITH, 32'hFF0E_CA86, 0);
    run("s4_sh0", 32'h1234_5678, 5'd0, SH_LOGICAL, 32'h1234_5678, 0);
    run("s4_ari31", 32'h8000_0000, 5'd31, SH_ARITH, 32'hFFFF_FFFF, 0);
    run("s4_inject", 32'h8765_4321, 5'd13, SH_LOGICAL, 32'h0004_3B2A, 1);
    for (int i = 0; i < 4; i++) begin
      rd = $urandom; rs = 5'($urandom); ra = 1'($urandom);
      sel = 1'(i);
      run("rand", rd, rs, ra, ref_sh(rd, rs, ra), 0);
    end
    sel = 1'b0;
    @(negedge clk);
    data = 32'hFFFF_0000; shamt = 5'd20; arith = SH_ARITH; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst/ready", 32'(rdy1), 32'd1);
    chk("midrst/data", q1, 32'h0);
    chk("midrst/done", 32'(done1), 32'd0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done1) pulses++;
    end
    chk("midrst/no_done", 32'(pulses), 32'd0);
    chk("midrst/data_later", q1, 32'h0);
    prev1 = '0; prev4 = '0;
    run("after_rst", 32'hFFFF_0000, 5'd20, SH_ARITH, 32'hFFFF_FFFF, 0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
